dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder_pkg.sv | 31 +++
 rtl/dmem_byte_lane.sv | 48 ++++
 rtl/dmem_responder.sv | 135 +++++++++++++
 tb/tb_dmem_responder.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// ---------------------------------------------------------------------------
// dmem_responder_pkg: access-size encodings, FSM state type, alignment helper
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package dmem_responder_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Illegal size is folded in here so a single flag covers all encoding faults.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SIZE_BYTE: misaligned = 1'b0;
      SIZE_HALF: misaligned = lane[0];
      SIZE_WORD: misaligned = (lane != 2'b00);
      default:   misaligned = 1'b1;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_byte_lane.sv
// ---------------------------------------------------------------------------
// dmem_byte_lane: store-lane merge and little-endian load extraction/extension
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dmem_byte_lane
  import dmem_responder_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  input  logic        sign_ext,
  input  logic [31:0] wdata,
  input  logic [31:0] word_in,
  output logic [31:0] merged,
  output logic [31:0] rdata
);

  logic [31:0] shifted;

  assign shifted = word_in >> {lane, 3'b000};

  always_comb begin
    merged = word_in;
    rdata  = '0;
    case (size)
      SIZE_BYTE: begin
        merged[{lane, 3'b000} +: 8] = wdata[7:0];
        rdata = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
      end
      SIZE_HALF: begin
        merged[{lane[1], 4'b0000} +: 16] = wdata[15:0];
        rdata = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
      end
      SIZE_WORD: begin
        merged = wdata;
        rdata  = word_in;
      end
      default: begin
        merged = word_in;
        rdata  = '0;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder: single-outstanding data-memory responder with fixed latency
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_sign_ext,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error
);

  localparam int          AW         = $clog2(DEPTH_WORDS);
  localparam logic [32:0] ADDR_LIMIT = 33'(4 * DEPTH_WORDS);
  localparam logic [3:0]  CNT_INIT   = 4'(LATENCY - 1);

  logic [31:0] mem [DEPTH_WORDS];

  state_t      state, state_nxt;
  logic [3:0]  count, count_nxt;
  logic        accept, enter_resp;
  logic        req_error;

  logic          cap_write, cap_sign_ext, cap_error;
  logic [1:0]    cap_size, cap_lane;
  logic [AW-1:0] cap_index;
  logic [31:0]   cap_wdata;
  logic [31:0]   lane_merged, lane_rdata;

  // Error is resolved at accept so storage can stay untouched on bad requests.
  assign req_error = misaligned(req_size, req_addr[1:0]) || ({1'b0, req_addr} >= ADDR_LIMIT);

  always_comb begin
    state_nxt  = state;
    count_nxt  = count;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    accept     = 1'b0;
    enter_resp = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept    = 1'b1;
          state_nxt = ST_WAIT;
          count_nxt = CNT_INIT;
        end
      end
      ST_WAIT: begin
        if (count == 4'd0) begin
          state_nxt  = ST_RESP;
          enter_resp = 1'b1;
        end else begin
          count_nxt = count - 4'd1;
        end
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      count <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cap_write    <= 1'b0;
      cap_sign_ext <= 1'b0;
      cap_error    <= 1'b0;
      cap_size     <= SIZE_BYTE;
      cap_lane     <= '0;
      cap_index    <= '0;
      cap_wdata    <= '0;
      rsp_rdata    <= '0;
      rsp_error    <= 1'b0;
    end else begin
      if (accept) begin
        cap_write    <= req_write;
        cap_sign_ext <= req_sign_ext;
        cap_error    <= req_error;
        cap_size     <= req_size;
        cap_lane     <= req_addr[1:0];
        cap_index    <= req_addr[AW+1:2];
        cap_wdata    <= req_wdata;
      end
      if (enter_resp) begin
        rsp_error <= cap_error;
        rsp_rdata <= (cap_error || cap_write) ? 32'd0 : lane_rdata;
      end
    end
  end

  // Storage has no reset so its contents survive reset_n.
  always_ff @(posedge clock) begin
    if (enter_resp && cap_write && !cap_error) mem[cap_index] <= lane_merged;
  end

  dmem_byte_lane u_lane (
    .size     (cap_size),
    .lane     (cap_lane),
    .sign_ext (cap_sign_ext),
    .wdata    (cap_wdata),
    .word_in  (mem[cap_index]),
    .merged   (lane_merged),
    .rdata    (lane_rdata)
  );

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// ---------------------------------------------------------------------------
// tb_dmem_responder: directed stimulus with queue scoreboard and response monitor
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_dmem_responder;

  localparam int LATENCY = 2;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [1:0]  req_size = 2'b00;
  logic        req_sign_ext = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_error;

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(LATENCY)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_size     (req_size),
    .req_sign_ext (req_sign_ext),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_error    (rsp_error)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   cyc = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [1:0] size, input logic sext,
                       input logic [31:0] exp_rdata, input logic exp_err, input bit scored);
    int n = 0;
    @(negedge clock);
    while (!req_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (!req_ready) begin
      check32("req_ready_timeout", {31'd0, req_ready}, 32'd1);
      return;
    end
    req_write    = wr;
    req_addr     = addr;
    req_wdata    = wdata;
    req_size     = size;
    req_sign_ext = sext;
    req_valid    = 1'b1;
    if (scored) sb.push_back('{exp_rdata, exp_err, cyc + 1});
    @(posedge clock);
    #1 req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (sb.size() != 0) check32("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  // Response monitor: latency on first sight, stability while held, data on handshake.
  logic        have_cur = 1'b0;
  logic [31:0] cur_rdata;
  logic        cur_err;
  always @(negedge clock) begin
    exp_t e;
    if (reset_n && rsp_valid) begin
      if (sb.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_rsp: rsp_valid=1 rdata=%h error=%b, expected no response",
                 rsp_rdata, rsp_error);
      end else begin
        if (!have_cur) begin
          check32("latency", 32'(cyc - sb[0].acc), 32'(LATENCY));
          have_cur  = 1'b1;
          cur_rdata = rsp_rdata;
          cur_err   = rsp_error;
        end else begin
          check32("hold_rdata", rsp_rdata, cur_rdata);
          check32("hold_error", {31'd0, rsp_error}, {31'd0, cur_err});
        end
        if (rsp_ready) begin
          e = sb.pop_front();
          check32("rsp_rdata", rsp_rdata, e.rdata);
          check32("rsp_error", {31'd0, rsp_error}, {31'd0, e.err});
          have_cur = 1'b0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    repeat (3) @(negedge clock);
    check32("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check32("reset_rsp_rdata", rsp_rdata, 32'd0);
    check32("reset_rsp_error", {31'd0, rsp_error}, 32'd0);
    reset_n = 1'b1;
    @(negedge clock);
    check32("reset_req_ready", {31'd0, req_ready}, 32'd1);

    // wr, addr, wdata, size, sext, exp_rdata, exp_err, scored
    issue(1, 32'h10,   32'hDEADBEEF, 2'b10, 1, 32'h0,        0, 1);
    issue(0, 32'h10,   32'h0,        2'b10, 1, 32'hDEADBEEF, 0, 1);
    issue(1, 32'h12,   32'hFFFFFF7F, 2'b00, 0, 32'h0,        0, 1);
    issue(0, 32'h13,   32'h0,        2'b00, 1, 32'hFFFFFFDE, 0, 1);
    issue(0, 32'h12,   32'h0,        2'b01, 0, 32'h0000DE7F, 0, 1);
    issue(0, 32'h10,   32'h0,        2'b10, 0, 32'hDE7FBEEF, 0, 1);
    issue(0, 32'h13,   32'h0,        2'b00, 0, 32'h000000DE, 0, 1);
    issue(0, 32'h12,   32'h0,        2'b01, 1, 32'hFFFFDE7F, 0, 1);
    issue(1, 32'h20,   32'h55667788, 2'b10, 0, 32'h0,        0, 1);
    issue(1, 32'h21,   32'h0000FFFF, 2'b01, 0, 32'h0,        1, 1);
    issue(0, 32'h4002, 32'h0,        2'b10, 0, 32'h0,        1, 1);
    issue(0, 32'h4000, 32'h0,        2'b10, 0, 32'h0,        1, 1);
    issue(1, 32'h20,   32'hFFFFFFFF, 2'b11, 0, 32'h0,        1, 1);
    issue(0, 32'h20,   32'h0,        2'b11, 0, 32'h0,        1, 1);
    issue(0, 32'h20,   32'h0,        2'b10, 0, 32'h55667788, 0, 1);
    issue(1, 32'h22,   32'hABCD1234, 2'b01, 0, 32'h0,        0, 1);
    issue(0, 32'h20,   32'h0,        2'b10, 0, 32'h12347788, 0, 1);
    issue(0, 32'h20,   32'h0,        2'b00, 1, 32'hFFFFFF88, 0, 1);
    issue(0, 32'h20,   32'h0,        2'b01, 0, 32'h00007788, 0, 1);
    issue(1, 32'hFFC,  32'hA5A5A5A5, 2'b10, 0, 32'h0,        0, 1);
    issue(0, 32'hFFC,  32'h0,        2'b10, 0, 32'hA5A5A5A5, 0, 1);
    drain();

    // Backpressure: response held five cycles, stray requests must be ignored.
    issue(1, 32'h40, 32'h11111111, 2'b10, 0, 32'h0, 0, 1);
    drain();
    rsp_ready = 1'b0;
    issue(0, 32'h10, 32'h0, 2'b10, 0, 32'hDE7FBEEF, 0, 1);
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge clock);
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      check32("hold_req_ready", {31'd0, req_ready}, 32'd0);
      check32("hold_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      @(posedge clock);
      #1;
      req_write = 1'b1;
      req_addr  = 32'h40;
      req_wdata = 32'hBAD0BAD0;
      req_size  = 2'b10;
      req_valid = (i < 4);
      if (i == 4) rsp_ready = 1'b1;
      @(negedge clock);
    end
    @(negedge clock);
    check32("resume_req_ready", {31'd0, req_ready}, 32'd1);
    check32("resume_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    issue(0, 32'h40, 32'h0, 2'b10, 0, 32'h11111111, 0, 1);
    drain();

    // Reset during WAIT abandons an uncommitted store.
    issue(1, 32'h30, 32'hCAFEF00D, 2'b10, 0, 32'h0, 0, 1);
    issue(0, 32'h30, 32'h0,        2'b10, 0, 32'hCAFEF00D, 0, 1);
    drain();
    issue(1, 32'h30, 32'h12345678, 2'b10, 0, 32'h0, 0, 0);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    check32("midreset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check32("midreset_rsp_rdata", rsp_rdata, 32'd0);
    check32("midreset_rsp_error", {31'd0, rsp_error}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (4) @(negedge clock);
    check32("postreset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check32("postreset_req_ready", {31'd0, req_ready}, 32'd1);
    issue(0, 32'h30, 32'h0, 2'b10, 0, 32'hCAFEF00D, 0, 1);
    drain();

    repeat (2) @(negedge clock);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire
